// File: rtl/ca_pkg.sv
// Shared types and helpers for the cellular-automaton row engine.
// Cell i of a row vector is bit i; packing maps it to byte i/8, bit 7-i%8.
package ca_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    SEED,
    IDLE,
    WRITE
  } state_t;

  localparam int MAX_CELLS = 256;

  function automatic int unsigned cell_byte(input int unsigned i);
    return i / 8;
  endfunction

  function automatic int unsigned cell_bit(input int unsigned i);
    return 7 - (i % 8);
  endfunction

  function automatic logic rule_bit(
    input logic [7:0] rule,
    input logic       l,
    input logic       c,
    input logic       r
  );
    return rule[{l, c, r}];
  endfunction

  // Reference successor for rows of up to MAX_CELLS cells (n in use).
  function automatic logic [MAX_CELLS-1:0] ca_next(
    input logic [MAX_CELLS-1:0] cur,
    input logic [7:0]           rule,
    input logic                 wrap,
    input int unsigned          n
  );
    logic [MAX_CELLS-1:0] nxt;
    logic l;
    logic r;
    nxt = '0;
    for (int i = 0; i < MAX_CELLS; i++) begin
      if (i < n) begin
        l = (i == 0) ? (wrap & cur[n-1])
                     : cur[(i + MAX_CELLS - 1) % MAX_CELLS];
        r = (i == n - 1) ? (wrap & cur[0])
                         : cur[(i + 1) % MAX_CELLS];
        nxt[i] = rule_bit(rule, l, cur[i], r);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ca_rule_row.sv
// Combinational successor of one automaton row: one rule lookup per cell.
// Edge neighbours come from the opposite end when wrap is set, else 0.
module ca_rule_row
  import ca_pkg::*;
#(
  parameter int CELLS = 64
) (
  input  logic [CELLS-1:0] cur,
  input  logic [7:0]       rule,
  input  logic             wrap,
  output logic [CELLS-1:0] nxt
);

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    logic l;
    logic r;
    if (i == 0) begin : g_l_edge
      assign l = wrap & cur[CELLS-1];
    end else begin : g_l_in
      assign l = cur[i-1];
    end
    if (i == CELLS - 1) begin : g_r_edge
      assign r = wrap & cur[0];
    end else begin : g_r_in
      assign r = cur[i+1];
    end
    assign nxt[i] = rule_bit(rule, l, cur[i], r);
  end

endmodule

// File: rtl/ca_row_engine.sv
// Elementary cellular-automaton generator writing one packed row per
// generation into a ring of ROWS rows on the display RAM A-port.
module ca_row_engine
  import ca_pkg::*;
#(
  parameter int CELLS          = 64,
  parameter int ROWS           = 128,
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [7:0]        rule,
  input  logic              wrap_mode,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              busy,
  output logic [RW-1:0]     row_idx,
  output logic              row_done
);

  localparam int BYTES = CELLS / 8;
  localparam int TOTAL = ROWS * BYTES;
  localparam int KW    = $clog2(BYTES + 1);
  localparam int KB    = $clog2(BYTES);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);
  localparam logic [RW-1:0]     ROW_END = RW'(ROWS - 1);
  localparam logic [KW-1:0]     K_END   = KW'(BYTES);
  localparam logic [CELLS-1:0]  SEED_ROW =
    {{(CELLS/2-1){1'b0}}, 1'b1, {(CELLS/2){1'b0}}};

  if (CELLS % 8 != 0 || CELLS < 16 || CELLS > MAX_CELLS) begin : g_bad_cells
    $error("ca_row_engine: CELLS must be a multiple of 8 in 16..256");
  end
  if (longint'(TOTAL) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("ca_row_engine: ROWS*CELLS/8 exceeds 2**ADDR_W");
  end

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [KW-1:0]     k, k_n;
  logic [CELLS-1:0]  cur, cur_n, nxt;
  logic [ADDR_W-1:0] addr_n, row_base;
  logic [7:0]        data_n;
  logic              we_n, done_n;
  logic [RW-1:0]     row_n;
  logic [7:0]        bytes [BYTES];

  ca_rule_row #(.CELLS(CELLS)) u_rule (
    .cur  (cur),
    .rule (rule),
    .wrap (wrap_mode),
    .nxt  (nxt)
  );

  // Pack the current row into RAM bytes, cell 0 at the MSB of byte 0.
  always_comb begin
    for (int b = 0; b < BYTES; b++) bytes[b] = '0;
    for (int c = 0; c < CELLS; c++)
      bytes[cell_byte(c)][cell_bit(c)] = cur[c];
  end

  assign row_base = ADDR_W'(row_idx) * BYTES_A;
  assign busy     = (state != IDLE);

  // Next-state and next-output logic; RAM outputs are registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    k_n     = k;
    cur_n   = cur;
    row_n   = row_idx;
    we_n    = 1'b0;
    addr_n  = ram_addr;
    data_n  = ram_data;
    done_n  = 1'b0;
    unique case (state)
      CLEAR: begin
        we_n   = 1'b1;
        addr_n = cnt;
        data_n = '0;
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = SEED;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SEED, WRITE: begin
        if (k == K_END) begin
          k_n     = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = row_base + ADDR_W'(k);
          data_n = bytes[k[KB-1:0]];
          k_n    = k + 1'b1;
        end
      end
      IDLE: begin
        if (step) begin
          cur_n   = nxt;
          row_n   = (row_idx == ROW_END) ? '0 : row_idx + 1'b1;
          state_n = WRITE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and RAM port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else                state <= SEED;
      cnt      <= '0;
      k        <= '0;
      cur      <= SEED_ROW;
      row_idx  <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      row_done <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      k        <= k_n;
      cur      <= cur_n;
      row_idx  <= row_n;
      ram_we   <= we_n;
      ram_addr <= addr_n;
      ram_data <= data_n;
      row_done <= done_n;
    end
  end

endmodule

// File: tb/tb_ca_row_engine.sv
// Directed bench for ca_row_engine with default parameters.
// A negedge monitor logs every RAM write into a shadow memory and queues.
module tb_ca_row_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic [7:0] rule;
  logic       wrap_mode;
  logic [9:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       busy;
  logic [6:0] row_idx;
  logic       row_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [1024];
  logic [9:0] la [$];
  logic [7:0] ld [$];
  int done_cnt = 0;
  int max_addr = 0;

  ca_row_engine dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .rule      (rule),
    .wrap_mode (wrap_mode),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .busy      (busy),
    .row_idx   (row_idx),
    .row_done  (row_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
      la.push_back(ram_addr);
      ld.push_back(ram_data);
      if (int'(ram_addr) > max_addr) max_addr <= int'(ram_addr);
    end
    if (row_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    tick();
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wait_idle("reset_to_idle", 3000);
  endtask

  task automatic do_step(input logic [7:0] r, input logic w);
    rule      = r;
    wrap_mode = w;
    step      = 1'b1;
    tick();
    step = 1'b0;
    wait_idle("step_to_idle", 50);
  endtask

  function automatic logic [63:0] row_mem(input int base);
    logic [63:0] v = '0;
    for (int b = 0; b < 8; b++) v = {v[55:0], mem[base+b]};
    return v;
  endfunction

  function automatic logic [63:0] row_log(input int s);
    logic [63:0] v = '0;
    for (int b = 0; b < 8; b++) v = {v[55:0], ld[s+b]};
    return v;
  endfunction

  function automatic int addr_bad(input int s, input int base, input int n);
    int bad = 0;
    for (int b = 0; b < n; b++)
      if (int'(la[s+b]) != base + b) bad++;
    return bad;
  endfunction

  initial begin
    int s;
    int d;
    int bad;
    int lat;
    rst       = 1'b1;
    step      = 1'b0;
    rule      = 8'd0;
    wrap_mode = 1'b0;

    tick();
    check("rst_we",       64'(ram_we),   64'd0);
    check("rst_addr",     64'(ram_addr), 64'd0);
    check("rst_data",     64'(ram_data), 64'd0);
    check("rst_busy",     64'(busy),     64'd1);
    check("rst_row_done", 64'(row_done), 64'd0);
    check("rst_row_idx",  64'(row_idx),  64'd0);

    s = la.size();
    d = done_cnt;
    tick();
    rst = 1'b0;
    wait_idle("clear_to_idle", 3000);
    check("clear_seed_count", 64'(la.size() - s), 64'd1032);
    bad = addr_bad(s, 0, 1024);
    for (int i = 0; i < 1024; i++) if (ld[s+i] !== 8'h00) bad++;
    check("clear_seq", 64'(bad), 64'd0);
    check("seed_addr", 64'(addr_bad(s + 1024, 0, 8)), 64'd0);
    check("seed_row", row_log(s + 1024), 64'h00000000_80000000);
    check("seed_done", 64'(done_cnt - d), 64'd1);
    check("seed_row_idx", 64'(row_idx), 64'd0);

    s = la.size();
    d = done_cnt;
    rule      = 8'd90;
    wrap_mode = 1'b0;
    step      = 1'b1;
    tick();
    step = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (row_done && lat == 0) lat = n;
    end
    check("r90_latency", 64'(lat), 64'd9);
    check("r90_count", 64'(la.size() - s), 64'd8);
    check("r90_addr", 64'(addr_bad(s, 8, 8)), 64'd0);
    check("r90_row", row_mem(8), 64'h00000001_40000000);
    check("r90_done", 64'(done_cnt - d), 64'd1);
    check("r90_row_idx", 64'(row_idx), 64'd1);

    do_reset();
    for (int i = 0; i < 33; i++) do_step(8'd170, 1'b1);
    check("r170w_row_idx", 64'(row_idx), 64'd33);
    check("r170w_row32", row_mem(256), 64'h80000000_00000000);
    check("r170w_row33", row_mem(264), 64'h00000000_00000001);

    do_reset();
    for (int i = 0; i < 33; i++) do_step(8'd170, 1'b0);
    check("r170n_row32", row_mem(256), 64'h80000000_00000000);
    check("r170n_row33", row_mem(264), 64'h00000000_00000000);

    do_reset();
    for (int i = 0; i < 127; i++) do_step(8'd204, 1'b0);
    check("r204_row_idx127", 64'(row_idx), 64'd127);
    check("r204_row127", row_mem(1016), 64'h00000000_80000000);
    s = la.size();
    do_step(8'd204, 1'b0);
    check("r204_wrap_idx", 64'(row_idx), 64'd0);
    check("r204_wrap_count", 64'(la.size() - s), 64'd8);
    check("r204_wrap_addr", 64'(addr_bad(s, 0, 8)), 64'd0);
    check("r204_wrap_row", row_log(s), 64'h00000000_80000000);

    s = la.size();
    d = done_cnt;
    rule = 8'd204;
    step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 2) rule = 8'd0;
    end
    step = 1'b0;
    wait_idle("hold_to_idle", 50);
    check("hold_count", 64'(la.size() - s), 64'd16);
    check("hold_done", 64'(done_cnt - d), 64'd2);
    check("hold_row_idx", 64'(row_idx), 64'd2);
    check("hold_addr", 64'(addr_bad(s, 8, 16)), 64'd0);
    check("hold_row1", row_log(s), 64'h00000000_80000000);
    check("hold_row2", row_log(s + 8), 64'h00000000_00000000);

    rule = 8'd204;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    tick();
    check("abort_pre_we", 64'(ram_we), 64'd1);
    check("abort_pre_addr", 64'(ram_addr), 64'd26);
    rst = 1'b1;
    tick();
    check("abort_we", 64'(ram_we), 64'd0);
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_row_idx", 64'(row_idx), 64'd0);
    rst = 1'b0;
    s = la.size();
    tick();
    check("abort_restart_we", 64'(ram_we), 64'd1);
    check("abort_restart_addr", 64'(ram_addr), 64'd0);
    wait_idle("abort_to_idle", 3000);
    check("abort_clear_count", 64'(la.size() - s), 64'd1032);
    check("abort_clear_addr", 64'(addr_bad(s, 0, 1024)), 64'd0);
    check("max_addr", 64'(max_addr), 64'd1023);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
